hamming74_serial_decoder: RTL and testbench
===========================================

// Module: hamming74_serial_decoder
// PURPOSE
//  Receive end of the error-correction link: consumes the serial bit stream
//  leaving the channel model, frames it into 7-bit Hamming(7,4) codewords,
//  corrects any single-bit error and emits the 4 data bits per codeword.
//  Sits directly after the channel; feeds the bench scoreboard / data sink.
// PARAMETERS
//  GAP_TIMEOUT  16  idle cycles (DATA_IN_VALID=0) tolerated mid-codeword; 0 = never time out
//  CNT_W        16  width of ERR_COUNT (only with HAM_ERR_CNT_EN)
// PORTS
//  CLK             in   1      clock; all logic on rising edge
//  RESET           in   1      synchronous, active-high reset
//  DATA_IN         in   1      serial codeword bit, position 1 first
//  DATA_IN_VALID   in   1      DATA_IN qualifier; one bit per asserted cycle
//  DATA_OUT        out  4      corrected data {d4,d3,d2,d1} = positions {7,6,5,3}
//  DATA_OUT_VALID  out  1      one-cycle pulse per decoded codeword
//  CORRECTED       out  1      with DATA_OUT_VALID: syndrome was nonzero, one bit flipped
//  SYNDROME        out  3      syndrome of the word, valid with DATA_OUT_VALID
//  ERR_COUNT       out  CNT_W  corrected-word count (HAM_ERR_CNT_EN only)
// BEHAVIOUR
//  - Reset: DATA_OUT=0, DATA_OUT_VALID=0, CORRECTED=0, SYNDROME=0, ERR_COUNT=0;
//    bit counter=0, shift reg=0, gap counter=0. RESET wins over any input.
//  - Codeword layout, positions 1..7: p1 p2 d1 p3 d2 d3 d4.
//    p1=d1^d2^d4, p2=d1^d3^d4, p3=d2^d3^d4.
//  - FSM: IDLE (cnt=0) -> COLLECT on a valid bit; COLLECT counts 1..6;
//    7th valid bit completes word, cnt->0 (IDLE) same edge.
//  - Decode on the 7th bit's edge; outputs registered: DATA_OUT_VALID high
//    exactly the cycle after the 7th valid bit (latency 1 cycle).
//  - Syndrome s={s3,s2,s1}: s1=c1^c3^c5^c7, s2=c2^c3^c6^c7, s3=c4^c5^c6^c7.
//    s!=0: invert bit at position s before extracting data; CORRECTED=1.
//    s==0: data passed unchanged; CORRECTED=0. Parity-position errors
//    (s=1,2,4) flag CORRECTED but leave DATA_OUT unaffected.
//  - Double errors are miscorrected by design (no detection); not flagged.
//  - Back-to-back streaming: bit 1 of next word may arrive in the cycle
//    right after bit 7; no bubble required, no bit lost.
//  - DATA_OUT, SYNDROME hold last value between pulses; CORRECTED and
//    DATA_OUT_VALID are 0 outside the pulse.
//  - Gap timeout (GAP_TIMEOUT>0): in COLLECT, gap counter increments each
//    cycle with DATA_IN_VALID=0, clears on a valid bit. When it reaches
//    GAP_TIMEOUT the partial word is discarded: cnt->0, IDLE, no output.
//    A valid bit in the same cycle as the limit is accepted (counter clears).
//  - Reset mid-word: partial word dropped, no DATA_OUT_VALID pulse.
// CONFIGURATION
//  HAM_ERR_CNT_EN defined: ERR_COUNT increments by 1 on every pulse with
//    CORRECTED=1; saturates at 2^CNT_W-1; cleared only by RESET.
//  HAM_ERR_CNT_EN undefined: ERR_COUNT port still present, tied to 0;
//    no counter logic.
// TESTING
//  1. Clean word: data 4'b1011 sent as bits 1,0,1,0,1,0,1 on 7 consecutive
//     cycles -> next cycle DATA_OUT=4'b1011, VALID=1, CORRECTED=0, SYNDROME=0.
//  2. Single error: bits 1,0,1,0,0,0,1 (pos5 flipped) -> DATA_OUT=4'b1011,
//     CORRECTED=1, SYNDROME=3'd5; ERR_COUNT=1 with HAM_ERR_CNT_EN.
//  3. Exhaustive: all 16 data values x {no error, each of 7 positions}
//     -> DATA_OUT always equals sent data; SYNDROME equals flipped position.
//  4. Streaming: 3 words back to back (21 valid cycles) -> 3 pulses at
//     cycles 8, 15, 22 after first bit, correct data each.
//  5. Gap: 3 bits, idle 16 cycles (GAP_TIMEOUT=16), then clean word
//     -> exactly one pulse, data of the second word; idle 15 instead
//     -> word continues across the gap.
//  6. Reset after bit 4, then full clean word -> no pulse for the partial,
//     one correct pulse; ERR_COUNT saturation with CNT_W=2 holds at 3.

Source files
------------

// File: rtl/hamming74_serial_decoder.sv
// hamming74_serial_decoder: frames a serial Hamming(7,4) stream, corrects single-bit errors, emits data nibbles.
// Optional corrected-word counter enabled by defining HAM_ERR_CNT_EN.
module hamming74_serial_decoder #(
    parameter int GAP_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             DATA_IN,
    input  logic             DATA_IN_VALID,
    output logic [3:0]       DATA_OUT,
    output logic             DATA_OUT_VALID,
    output logic             CORRECTED,
    output logic [2:0]       SYNDROME,
    output logic [CNT_W-1:0] ERR_COUNT
);
    localparam int GW = GAP_TIMEOUT > 1 ? $clog2(GAP_TIMEOUT) : 1;
    typedef enum logic {IDLE, COLLECT} state_t;
    state_t state, state_n;
    logic [2:0] cnt, cnt_n, syn;
    logic [6:0] sr, sr_n, word;
    logic [GW-1:0] gap, gap_n;
    logic [3:0] data;
    logic done;
    // word[0] holds position 1 once the 7th bit is shifted in from the top
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        sr_n = sr;
        gap_n = gap;
        done = 1'b0;
        word = {DATA_IN, sr[6:1]};
        if (DATA_IN_VALID) begin
            sr_n = word;
            gap_n = '0;
            done = cnt == 3'd6;
            cnt_n = done ? 3'd0 : cnt + 3'd1;
            state_n = done ? IDLE : COLLECT;
        end else if (state == COLLECT) begin
            gap_n = gap + 1'b1;
            if (GAP_TIMEOUT != 0 && gap == GW'(GAP_TIMEOUT - 1)) begin
                state_n = IDLE;
                cnt_n = 3'd0;
                gap_n = '0;
                sr_n = '0;
            end
        end
        syn = {word[3] ^ word[4] ^ word[5] ^ word[6],
               word[1] ^ word[2] ^ word[5] ^ word[6],
               word[0] ^ word[2] ^ word[4] ^ word[6]};
        data = {word[6], word[5], word[4], word[2]} ^ {syn == 3'd7, syn == 3'd6, syn == 3'd5, syn == 3'd3};
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            cnt <= '0;
            sr <= '0;
            gap <= '0;
            DATA_OUT <= '0;
            DATA_OUT_VALID <= 1'b0;
            CORRECTED <= 1'b0;
            SYNDROME <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            sr <= sr_n;
            gap <= gap_n;
            DATA_OUT_VALID <= done;
            CORRECTED <= done && syn != 3'd0;
            if (done) begin
                DATA_OUT <= data;
                SYNDROME <= syn;
            end
        end
    end
`ifdef HAM_ERR_CNT_EN
    always_ff @(posedge CLK) begin
        if (RESET)
            ERR_COUNT <= '0;
        else if (done && syn != 3'd0 && ERR_COUNT != '1)
            ERR_COUNT <= ERR_COUNT + CNT_W'(1);
    end
`else
    assign ERR_COUNT = '0;
`endif
endmodule

// File: tb/tb_hamming74_serial_decoder.sv
// tb_hamming74_serial_decoder: directed checks of framing, correction, streaming, gap timeout and reset.
module tb_hamming74_serial_decoder;
`ifdef HAM_ERR_CNT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif
    logic CLK = 1'b0, RESET = 1'b1, DATA_IN = 1'b0, DATA_IN_VALID = 1'b0;
    logic [3:0] DATA_OUT;
    logic DATA_OUT_VALID, CORRECTED;
    logic [2:0] SYNDROME;
    logic [1:0] ERR_COUNT;
    int compared = 0, mismatched = 0;
    int np = 0, cyc = 0, exp_err = 0, n0 = 0;
    bit armed = 1'b0;
    logic [3:0] pd[8];
    logic [2:0] ps[8];
    logic pk[8];
    int pc[8];

    hamming74_serial_decoder #(.GAP_TIMEOUT(16), .CNT_W(2)) dut (
        .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN), .DATA_IN_VALID(DATA_IN_VALID),
        .DATA_OUT(DATA_OUT), .DATA_OUT_VALID(DATA_OUT_VALID), .CORRECTED(CORRECTED),
        .SYNDROME(SYNDROME), .ERR_COUNT(ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] enc(input logic [3:0] d);
        enc = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    function automatic logic [1:0] want_err();
        want_err = EN ? 2'(exp_err > 3 ? 3 : exp_err) : 2'd0;
    endfunction

    task automatic tick(input logic b, input logic v);
        @(negedge CLK);
        cyc++;
        if (DATA_OUT_VALID === 1'b1) begin
            if (np < 8) begin
                pd[np] = DATA_OUT; ps[np] = SYNDROME; pk[np] = CORRECTED; pc[np] = cyc;
            end
            np++;
        end else if (armed) begin
            compared++;
            if (CORRECTED !== 1'b0) begin
                mismatched++;
                $display("FAIL corrected_idle: got %b want 0 at tick %0d", CORRECTED, cyc);
            end
        end
        DATA_IN = b;
        DATA_IN_VALID = v;
    endtask

    task automatic send(input logic [6:0] c);
        for (int i = 0; i < 7; i++) tick(c[i], 1'b1);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) tick(1'b0, 1'b0);
        RESET = 1'b0;
        compared++;
        if ({DATA_OUT, DATA_OUT_VALID, CORRECTED, SYNDROME} !== 9'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b%b%b%b want all zero", DATA_OUT, DATA_OUT_VALID, CORRECTED, SYNDROME);
        end
        compared++;
        if (ERR_COUNT !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_err_count: got %0d want 0", ERR_COUNT);
        end
        armed = 1'b1;
        np = 0;
    endtask

    task automatic test_clean();
        np = 0;
        n0 = cyc + 1;
        send(7'b1010101);
        tick(1'b0, 1'b0);
        compared++;
        if (np !== 1 || pd[0] !== 4'b1011 || pk[0] !== 1'b0 || ps[0] !== 3'd0) begin
            mismatched++;
            $display("FAIL clean_word: got n=%0d d=%b c=%b s=%0d want n=1 d=1011 c=0 s=0", np, pd[0], pk[0], ps[0]);
        end
        compared++;
        if (pc[0] - n0 + 1 !== 8) begin
            mismatched++;
            $display("FAIL clean_latency: got cycle %0d want 8", pc[0] - n0 + 1);
        end
        repeat (3) tick(1'b0, 1'b0);
        compared++;
        if (np !== 1 || DATA_OUT !== 4'b1011 || SYNDROME !== 3'd0) begin
            mismatched++;
            $display("FAIL clean_hold: got n=%0d d=%b s=%0d want n=1 d=1011 s=0", np, DATA_OUT, SYNDROME);
        end
    endtask

    task automatic test_single();
        np = 0;
        send(7'b1000101);
        exp_err++;
        tick(1'b0, 1'b0);
        compared++;
        if (np !== 1 || pd[0] !== 4'b1011 || pk[0] !== 1'b1 || ps[0] !== 3'd5) begin
            mismatched++;
            $display("FAIL single_error: got n=%0d d=%b c=%b s=%0d want n=1 d=1011 c=1 s=5", np, pd[0], pk[0], ps[0]);
        end
        compared++;
        if (ERR_COUNT !== want_err()) begin
            mismatched++;
            $display("FAIL single_err_count: got %0d want %0d", ERR_COUNT, want_err());
        end
    endtask

    task automatic test_exhaustive();
        logic [6:0] c;
        for (int d = 0; d < 16; d++) begin
            for (int p = 0; p < 8; p++) begin
                c = enc(4'(d));
                if (p != 0) begin
                    c[p-1] = ~c[p-1];
                    exp_err++;
                end
                np = 0;
                send(c);
                tick(1'b0, 1'b0);
                compared++;
                if (np !== 1 || pd[0] !== 4'(d) || ps[0] !== 3'(p) || pk[0] !== (p != 0)) begin
                    mismatched++;
                    $display("FAIL exhaustive d=%0d pos=%0d: got n=%0d d=%0d s=%0d c=%b want d=%0d s=%0d",
                             d, p, np, pd[0], ps[0], pk[0], d, p);
                end
            end
        end
        compared++;
        if (ERR_COUNT !== want_err()) begin
            mismatched++;
            $display("FAIL saturate_err_count: got %0d want %0d", ERR_COUNT, want_err());
        end
        c = enc(4'd9) ^ 7'b0000010;
        exp_err++;
        send(c);
        tick(1'b0, 1'b0);
        compared++;
        if (ERR_COUNT !== want_err()) begin
            mismatched++;
            $display("FAIL saturate_hold: got %0d want %0d", ERR_COUNT, want_err());
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w[3];
        w[0] = 4'd3; w[1] = 4'd12; w[2] = 4'd9;
        np = 0;
        n0 = cyc + 1;
        for (int k = 0; k < 3; k++) send(enc(w[k]));
        tick(1'b0, 1'b0);
        compared++;
        if (np !== 3) begin
            mismatched++;
            $display("FAIL stream_count: got %0d want 3", np);
        end
        for (int k = 0; k < 3; k++) begin
            compared++;
            if (pd[k] !== w[k] || pc[k] - n0 + 1 !== 8 + 7 * k) begin
                mismatched++;
                $display("FAIL stream_word%0d: got d=%0d cycle %0d want d=%0d cycle %0d",
                         k, pd[k], pc[k] - n0 + 1, w[k], 8 + 7 * k);
            end
        end
    endtask

    task automatic test_gap();
        logic [6:0] a;
        a = enc(4'd5);
        np = 0;
        for (int i = 0; i < 3; i++) tick(a[i], 1'b1);
        repeat (16) tick(1'b0, 1'b0);
        send(enc(4'd12));
        tick(1'b0, 1'b0);
        compared++;
        if (np !== 1 || pd[0] !== 4'd12) begin
            mismatched++;
            $display("FAIL gap_timeout: got n=%0d d=%0d want n=1 d=12", np, pd[0]);
        end
        np = 0;
        for (int i = 0; i < 3; i++) tick(a[i], 1'b1);
        repeat (15) tick(1'b0, 1'b0);
        for (int i = 3; i < 7; i++) tick(a[i], 1'b1);
        send(enc(4'd12));
        tick(1'b0, 1'b0);
        compared++;
        if (np !== 2 || pd[0] !== 4'd5 || pd[1] !== 4'd12) begin
            mismatched++;
            $display("FAIL gap_continue: got n=%0d d0=%0d d1=%0d want n=2 d0=5 d1=12", np, pd[0], pd[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] a;
        a = enc(4'd10);
        np = 0;
        for (int i = 0; i < 4; i++) tick(a[i], 1'b1);
        tick(1'b0, 1'b0);
        RESET = 1'b1;
        tick(1'b0, 1'b0);
        RESET = 1'b0;
        exp_err = 0;
        compared++;
        if (ERR_COUNT !== 2'd0 || DATA_OUT !== 4'd0) begin
            mismatched++;
            $display("FAIL reset_mid_clear: got err=%0d d=%0d want 0 0", ERR_COUNT, DATA_OUT);
        end
        send(enc(4'd6));
        tick(1'b0, 1'b0);
        compared++;
        if (np !== 1 || pd[0] !== 4'd6 || pk[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_word: got n=%0d d=%0d c=%b want n=1 d=6 c=0", np, pd[0], pk[0]);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single();
        test_exhaustive();
        test_back_to_back();
        test_gap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
